// File: rtl/clause_db_pkg.sv
// Shared definitions for the clause_db memory and its requester.
package clause_db_pkg;

    localparam int def_data_size    = 8;
    localparam int def_address_size = 8;
    localparam int def_mem_size     = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ACCESS,
        RESP,
        FINISH
    } state_t;

endpackage

// File: rtl/clause_db_requester.sv
// Initiator for the clause_db handshake: single-word writes and burst reads
// from the BCP engine, read words returned on a valid/ready stream.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// ARM    | waiting for clause_db to report ready (mem_work=1)
// ACCESS | mem_request low, waiting for mem_work to fall
// RESP   | read word presented, waiting for rsp_ready
// FINISH | pulse done, return to IDLE
module clause_db_requester
    import clause_db_pkg::*;
#(
    parameter int data_size    = def_data_size,
    parameter int address_size = def_address_size,
    parameter int mem_size     = def_mem_size,
    parameter int len_size     = 4,
    parameter int timeout      = 15
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [address_size-1:0] cmd_addr,
    input  logic [len_size-1:0]     cmd_len,
    input  logic [data_size-1:0]    cmd_wdata,
    output logic                    rsp_valid,
    output logic [data_size-1:0]    rsp_data,
    output logic                    rsp_last,
    input  logic                    rsp_ready,
    output logic                    done,
    output logic                    err,
    output logic                    mem_request,
    output logic                    data_read,
    output logic                    data_write,
    output logic [address_size-1:0] address,
    output logic [data_size-1:0]    d_in,
    input  logic [data_size-1:0]    d_out,
    input  logic                    mem_work
);

    localparam int tmr_w = $clog2(timeout + 1);
    localparam logic [tmr_w-1:0] tmr_load = tmr_w'(timeout - 1);

    state_t                  state;
    logic [len_size-1:0]     remaining;
    logic                    is_write;
    logic [tmr_w-1:0]        timer;
    logic [address_size-1:0] next_addr;

    assign next_addr = (address == address_size'(mem_size - 1)) ? '0
                                                                : address + address_size'(1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_last    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            mem_request <= 1'b1;
            data_read   <= 1'b0;
            data_write  <= 1'b0;
            address     <= '0;
            d_in        <= '0;
            remaining   <= '0;
            is_write    <= 1'b0;
            timer       <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        is_write  <= cmd_write;
                        remaining <= cmd_len;
                        address   <= cmd_addr;
                        d_in      <= cmd_wdata;
                        if (!cmd_write && cmd_len == '0) begin
                            state <= FINISH;
                        end else begin
                            data_read  <= ~cmd_write;
                            data_write <= cmd_write;
                            timer      <= tmr_load;
                            state      <= ARM;
                        end
                    end
                end
                ARM, ACCESS: begin
                    // ARM leaves on mem_work high, ACCESS on mem_work low
                    if (state == ARM && mem_work == 1'b1) begin
                        mem_request <= 1'b0;
                        timer       <= tmr_load;
                        state       <= ACCESS;
                    end else if (state == ACCESS && mem_work == 1'b0) begin
                        mem_request <= 1'b1;
                        data_read   <= 1'b0;
                        data_write  <= 1'b0;
                        if (is_write) begin
                            state <= FINISH;
                        end else begin
                            rsp_data  <= d_out;
                            rsp_valid <= 1'b1;
                            rsp_last  <= (remaining == len_size'(1));
                            state     <= RESP;
                        end
                    end else if (timer == '0) begin
                        mem_request <= 1'b1;
                        data_read   <= 1'b0;
                        data_write  <= 1'b0;
                        err         <= 1'b1;
                        done        <= 1'b1;
                        cmd_ready   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer - tmr_w'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        remaining <= remaining - len_size'(1);
                        if (remaining > len_size'(1)) begin
                            address   <= next_addr;
                            data_read <= 1'b1;
                            timer     <= tmr_load;
                            state     <= ARM;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    done      <= 1'b1;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clause_db_requester.sv
// Directed bench for clause_db_requester with a behavioural clause_db responder.
module tb_clause_db_requester;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_last, rsp_ready;
    logic [7:0] rsp_data;
    logic       done, err;
    logic       mem_request, data_read, data_write, mem_work;
    logic [7:0] address, d_in, d_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int cyc;
    logic       stuck;
    logic [7:0] mem [0:7];
    logic [7:0] rsp_q[$];
    logic       last_q[$];
    logic [7:0] addr_q[$];

    always #5 clock = ~clock;

    clause_db_requester dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .rsp_ready(rsp_ready), .done(done), .err(err),
        .mem_request(mem_request), .data_read(data_read), .data_write(data_write),
        .address(address), .d_in(d_in), .d_out(d_out), .mem_work(mem_work)
    );

    // clause_db stand-in: access on req low + work high, re-arm once req returns high
    always @(posedge clock) begin
        if (!reset || stuck) begin
            mem_work <= 1'b0;
        end else if (mem_work && !mem_request) begin
            if (data_write) mem[address[2:0]] <= d_in;
            d_out    <= mem[address[2:0]];
            mem_work <= 1'b0;
        end else if (!mem_work && mem_request) begin
            mem_work <= 1'b1;
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            if (rsp_valid && rsp_ready) begin
                rsp_q.push_back(rsp_data);
                last_q.push_back(rsp_last);
            end
            if (!mem_request && mem_work) addr_q.push_back(address);
            if (done) n_done++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_q();
        rsp_q.delete();
        last_q.delete();
        addr_q.delete();
    endtask

    task automatic send_cmd(input logic w, input logic [7:0] a, input logic [3:0] l,
                            input logic [7:0] wd);
        int n = 0;
        @(negedge clock);
        while (!cmd_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("cmd_ready_wait", 0, 1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_wdata = wd;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound, output int c);
        c = 1;
        while (!done && c < bound) begin
            @(negedge clock);
            c++;
        end
        if (!done) chk({tag, "_done_wait"}, 0, 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!rsp_valid) chk({tag, "_valid_wait"}, 0, 1);
    endtask

    initial begin
        logic [7:0] exp_b [4];
        logic [7:0] exp_w [3];
        logic [7:0] exp_a [3];
        int bad_data, bad_req, n_addr, nd;

        exp_b = '{8'd11, 8'd22, 8'd33, 8'd44};
        exp_w = '{8'h66, 8'h77, 8'h80};
        exp_a = '{8'd6, 8'd7, 8'd0};
        reset = 1'b0; stuck = 1'b0; rsp_ready = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_wdata = '0;
        repeat (3) @(negedge clock);
        chk("rst_mem_request", mem_request, 1);
        chk("rst_strobes", {data_read, data_write}, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp", {rsp_valid, rsp_last, done, err}, 0);
        chk("rst_buses", {address, d_in, rsp_data}, 0);
        reset = 1'b1;

        // single write then read back
        send_cmd(1'b1, 8'd3, 4'd0, 8'hA5);
        wait_done("wr", 40, cyc);
        chk("wr_latency", cyc, 5);
        chk("wr_mem", mem[3], 8'hA5);
        clear_q();
        send_cmd(1'b0, 8'd3, 4'd1, 8'h00);
        wait_done("rd1", 40, cyc);
        chk("rd1_latency", cyc, 6);
        chk("rd1_count", rsp_q.size(), 1);
        chk("rd1_data", rsp_q.size() > 0 ? rsp_q[0] : 8'hxx, 8'hA5);
        chk("rd1_last", last_q.size() > 0 ? last_q[0] : 1'bx, 1);

        for (int i = 0; i < 4; i++) begin
            send_cmd(1'b1, 8'(2 + i), 4'd0, exp_b[i]);
            wait_done("preload", 40, cyc);
        end

        // four-word burst, consumer always ready
        clear_q();
        send_cmd(1'b0, 8'd2, 4'd4, 8'h00);
        wait_done("burst", 100, cyc);
        chk("burst_count", rsp_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("burst_data%0d", i), rsp_q.size() > i ? rsp_q[i] : 8'hxx, exp_b[i]);
            chk($sformatf("burst_last%0d", i), last_q.size() > i ? last_q[i] : 1'bx, i == 3);
            chk($sformatf("burst_addr%0d", i), addr_q.size() > i ? addr_q[i] : 8'hxx, 2 + i);
        end

        // same burst, second word stalled for 5 cycles
        clear_q();
        send_cmd(1'b0, 8'd2, 4'd4, 8'h00);
        wait_valid("stall_w1");
        @(negedge clock);
        wait_valid("stall_w2");
        rsp_ready = 1'b0;
        bad_data = 0; bad_req = 0; n_addr = addr_q.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (!rsp_valid || rsp_data !== 8'd22) bad_data++;
            if (mem_request !== 1'b1) bad_req++;
        end
        chk("stall_hold", bad_data, 0);
        chk("stall_no_req", bad_req, 0);
        chk("stall_no_access", addr_q.size(), n_addr);
        rsp_ready = 1'b1;
        wait_done("stall", 100, cyc);
        chk("stall_count", rsp_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("stall_data%0d", i), rsp_q.size() > i ? rsp_q[i] : 8'hxx, exp_b[i]);

        // address wrap 6,7,0
        for (int i = 0; i < 3; i++) begin
            send_cmd(1'b1, exp_a[i], 4'd0, exp_w[i]);
            wait_done("wrap_wr", 40, cyc);
        end
        clear_q();
        send_cmd(1'b0, 8'd6, 4'd3, 8'h00);
        wait_done("wrap", 100, cyc);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wrap_addr%0d", i), addr_q.size() > i ? addr_q[i] : 8'hxx, exp_a[i]);
            chk($sformatf("wrap_data%0d", i), rsp_q.size() > i ? rsp_q[i] : 8'hxx, exp_w[i]);
        end

        // zero-length read
        clear_q();
        send_cmd(1'b0, 8'd4, 4'd0, 8'h00);
        wait_done("len0", 20, cyc);
        chk("len0_latency", cyc, 2);
        chk("len0_no_access", addr_q.size(), 0);
        chk("len0_no_rsp", rsp_q.size(), 0);

        // clause_db never ready
        stuck = 1'b1;
        send_cmd(1'b1, 8'd1, 4'd0, 8'h5A);
        wait_done("tmo", 40, cyc);
        chk("tmo_latency", cyc, 16);
        chk("tmo_err", err, 1);
        chk("tmo_mem_request", mem_request, 1);
        chk("tmo_strobes", {data_read, data_write}, 0);
        chk("tmo_idle", cmd_ready, 1);
        @(negedge clock);
        chk("tmo_err_pulse", err, 0);
        stuck = 1'b0;

        // reset during ACCESS of a burst
        clear_q();
        send_cmd(1'b0, 8'd2, 4'd4, 8'h00);
        @(negedge clock);
        chk("mid_in_access", mem_request, 0);
        reset = 1'b0;
        nd = n_done;
        @(negedge clock);
        chk("mid_mem_request", mem_request, 1);
        chk("mid_rsp_valid", rsp_valid, 0);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        chk("mid_no_done", n_done, nd);
        chk("mid_no_rsp", rsp_q.size(), 0);
        clear_q();
        send_cmd(1'b0, 8'd5, 4'd1, 8'h00);
        wait_done("post_rst", 40, cyc);
        chk("post_rst_data", rsp_q.size() > 0 ? rsp_q[0] : 8'hxx, 8'd44);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
